pwm_duty_meter: RTL and testbench

- Receive-side counterpart of the breathing-LED PWM generator: samples an incoming PWM line and measures its high time and period in sys_clk cycles.
- Used in loop-back checks and for capturing external PWM (fan tach, servo-style inputs).
- Reports a one-cycle valid strobe per completed period.
- Flags a stuck-high or stuck-low line when no edge arrives within a timeout.

---
 rtl/pwm_duty_meter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter
//
// Samples an asynchronous PWM line and measures, in sys_clk cycles, how long
// the line was high and how long one full period lasted. A one-cycle strobe
// accompanies every completed period. A line that shows no edge for
// TIMEOUT_MAX cycles is flagged as stuck high or stuck low.
//
// All results are referenced to the synchronized level pwm_s. An edge on
// pwm_in_i reaches the measurement logic 3 sys_clk cycles later.
//
// Optional feature (macro PWM_METER_DEGLITCH_EN):
//   When defined, a filter between the synchronizer and the edge detector
//   lets pwm_s follow the synchronized line only after it has held a new level
//   for DEGLITCH_LEN consecutive cycles. Shorter pulses vanish, and edge
//   latency becomes 3 + DEGLITCH_LEN cycles. Durations of clean pulses are
//   unchanged because both edges are delayed by the same amount. When the
//   macro is undefined there is no filter and a 1-cycle glitch is a pulse.
//
// Parameters:
//   CNT_W        width of the cycle counter and of the measurement outputs
//   TIMEOUT_MAX  edge-free cycles before a stuck flag is raised
//                (must be < 2^CNT_W - 1)
//   DEGLITCH_LEN stable samples required by the optional filter
//
// Ports:
//   sys_clk_i     system clock, rising edge
//   sys_rst_n_i   asynchronous active-low reset
//   pwm_in_i      asynchronous PWM line
//   high_time_o   cycles pwm_s was high in the last complete period
//   period_o      cycles between the last two rising edges of pwm_s
//   meas_valid_o  one-cycle strobe when high_time_o/period_o update
//   stuck_high_o  line held high for TIMEOUT_MAX cycles (clears on a fall)
//   stuck_low_o   line held low for TIMEOUT_MAX cycles (clears on a rise)
// -----------------------------------------------------------------------------
module pwm_duty_meter #(
  parameter int unsigned      CNT_W        = 20,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX  = 20'd999_999,
  parameter logic [2:0]       DEGLITCH_LEN = 3'd3
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_n_i,
  input  logic             pwm_in_i,
  output logic [CNT_W-1:0] high_time_o,
  output logic [CNT_W-1:0] period_o,
  output logic             meas_valid_o,
  output logic             stuck_high_o,
  output logic             stuck_low_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // Input path
  logic sync1_q;
  logic sync2_q;
  logic pwm_s;
  logic pwm_d_q;
  logic rise_s;
  logic fall_s;

  // Measurement state
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hi_tmp_q;
  logic [CNT_W-1:0] hi_tmp_d;
  logic             cnt_at_max_s;

  // Registered outputs
  logic [CNT_W-1:0] high_time_q;
  logic [CNT_W-1:0] high_time_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic             meas_valid_q;
  logic             meas_valid_d;
  logic             stuck_high_q;
  logic             stuck_high_d;
  logic             stuck_low_q;
  logic             stuck_low_d;

  // Two-flop synchronizer on the raw line plus the one-cycle-delayed copy
  // of pwm_s used for edge detection.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in_i;
      sync2_q <= sync1_q;
      pwm_d_q <= pwm_s;
    end
  end

`ifdef PWM_METER_DEGLITCH_EN
  logic [2:0] stab_q;
  logic [2:0] stab_d;
  logic       filt_q;
  logic       filt_d;

  // Filter next state: count consecutive samples that disagree with the
  // filtered level; adopt the new level once the run reaches DEGLITCH_LEN.
  always_comb begin
    stab_d = stab_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      stab_d = 3'd0;
    end else if ((stab_q + 3'd1) >= DEGLITCH_LEN) begin
      filt_d = sync2_q;
      stab_d = 3'd0;
    end else begin
      stab_d = stab_q + 3'd1;
    end
  end

  // Filter state registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      stab_q <= 3'd0;
      filt_q <= 1'b0;
    end else begin
      stab_q <= stab_d;
      filt_q <= filt_d;
    end
  end

  assign pwm_s = filt_q;
`else
  logic unused_deglitch_s;

  assign unused_deglitch_s = ^DEGLITCH_LEN;
  assign pwm_s             = sync2_q;
`endif

  assign rise_s       = pwm_s & ~pwm_d_q;
  assign fall_s       = ~pwm_s & pwm_d_q;
  assign cnt_at_max_s = (cnt_q == TIMEOUT_MAX);

  // Next-state logic: counter, FSM transitions, measurement latching and
  // stuck-flag handling. Edges are tested before the timeout so that an
  // edge arriving on the same cycle as the timeout wins.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_tmp_d     = hi_tmp_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    // cnt holds the number of cycles since the last rise (saturating).
    // While idle a fall also restarts it, so the idle timeout measures time
    // since the last edge of either polarity; otherwise a line that has
    // just recovered from stuck-high would be flagged stuck-low at once.
    if (rise_s) begin
      cnt_d = CNT_ONE;
    end else if (fall_s && (state_q == S_IDLE)) begin
      cnt_d = CNT_ONE;
    end else if (cnt_at_max_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (fall_s) begin
      stuck_high_d = 1'b0;
    end else begin
      stuck_high_d = stuck_high_q;
    end

    if (rise_s) begin
      stuck_low_d = 1'b0;
    end else begin
      stuck_low_d = stuck_low_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rise_s) begin
          state_d = S_HIGH;
        end else if (fall_s) begin
          state_d = S_IDLE;
        end else if (cnt_at_max_s) begin
          // Static line: flag whichever level it is sitting at.
          stuck_high_d = pwm_s;
          stuck_low_d  = ~pwm_s;
          state_d      = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HIGH: begin
        if (fall_s) begin
          hi_tmp_d = cnt_q;
          state_d  = S_LOW;
        end else if (cnt_at_max_s) begin
          stuck_high_d = 1'b1;
          stuck_low_d  = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_HIGH;
        end
      end

      S_LOW: begin
        if (rise_s) begin
          period_d     = cnt_q;
          high_time_d  = hi_tmp_q;
          meas_valid_d = 1'b1;
          state_d      = S_HIGH;
        end else if (cnt_at_max_s) begin
          stuck_low_d  = 1'b1;
          stuck_high_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_LOW;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Measurement state and output registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      hi_tmp_q     <= CNT_ZERO;
      high_time_q  <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      meas_valid_q <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_tmp_q     <= hi_tmp_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign high_time_o  = high_time_q;
  assign period_o     = period_q;
  assign meas_valid_o = meas_valid_q;
  assign stuck_high_o = stuck_high_q;
  assign stuck_low_o  = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_meter
//
// Drives pwm_duty_meter (TIMEOUT_MAX = 50) with directed and random PWM
// waveforms and compares every output on every cycle against a reference
// model that works on timestamps of rising/falling edges of the synchronized
// line rather than on counters.
// -----------------------------------------------------------------------------
module tb_pwm_duty_meter;

  localparam int CNT_W  = 20;
  localparam int TMO    = 50;
  localparam int DG_LEN = 3;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_MAX (20'd50),
    .DEGLITCH_LEN(3'd3)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .pwm_in_i    (pwm_in),
    .high_time_o (high_time),
    .period_o    (period),
    .meas_valid_o(meas_valid),
    .stuck_high_o(stuck_high),
    .stuck_low_o (stuck_low)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit line_q[$];      // values driven on pwm_in, oldest first
  int k_now = 0;      // index of the next model step (one per clock edge)
  bit m_open;         // a rise has been seen and no timeout since
  int m_rise;         // step of the last rise
  int m_fall;         // step of the fall after m_rise, -1 if none yet
  int m_ref;          // step the idle timeout is measured from
  bit m_filt;
  bit m_fprev;
  int m_run;
  bit e_mv, e_sh, e_sl;
  int e_ht, e_per;

  // Observation helpers for scenario-level checks
  int mv_seen;
  int min_per;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    repeat (3) line_q.push_back(1'b0);
    m_filt  = 1'b0;
    m_fprev = 1'b0;
    m_run   = 0;
    m_open  = 1'b0;
    m_rise  = 0;
    m_fall  = -1;
    m_ref   = k_now;
    e_mv    = 1'b0;
    e_sh    = 1'b0;
    e_sl    = 1'b0;
    e_ht    = 0;
    e_per   = 0;
  endtask

  // One clock edge of the reference: find the synchronized level, detect
  // edges, and apply the measurement/timeout rules using elapsed times.
  task automatic model_step();
    bit s, d, rise, fall;
    int n;
    n = line_q.size();
`ifdef PWM_METER_DEGLITCH_EN
    s       = m_filt;
    d       = m_fprev;
    m_fprev = m_filt;
    if (line_q[n-3] == m_filt) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run >= DG_LEN) begin
        m_filt = line_q[n-3];
        m_run  = 0;
      end
    end
`else
    s = line_q[n-3];
    d = line_q[n-4];
`endif
    rise = s & ~d;
    fall = ~s & d;
    e_mv = 1'b0;
    if (fall) e_sh = 1'b0;
    if (rise) e_sl = 1'b0;
    if (!m_open) begin
      if (rise) begin
        m_open = 1'b1;
        m_rise = k_now;
        m_fall = -1;
      end else if (fall) begin
        m_ref = k_now;
      end else if (k_now - m_ref >= TMO) begin
        e_sh = s;
        e_sl = ~s;
      end
    end else if (m_fall < 0) begin
      if (fall) begin
        m_fall = k_now;
      end else if (k_now - m_rise >= TMO) begin
        e_sh   = 1'b1;
        e_sl   = 1'b0;
        m_open = 1'b0;
        m_ref  = m_rise;
      end
    end else begin
      if (rise) begin
        e_mv   = 1'b1;
        e_ht   = m_fall - m_rise;
        e_per  = k_now - m_rise;
        m_rise = k_now;
        m_fall = -1;
      end else if (k_now - m_rise >= TMO) begin
        e_sl   = 1'b1;
        e_sh   = 1'b0;
        m_open = 1'b0;
        m_ref  = m_rise;
      end
    end
    k_now++;
  endtask

  // Compare outputs (result of the previous edge), then drive the next value.
  task automatic drive_cycle(input bit v);
    @(negedge clk);
    chk("meas_valid", 32'(meas_valid), 32'(e_mv));
    chk("stuck_high", 32'(stuck_high), 32'(e_sh));
    chk("stuck_low", 32'(stuck_low), 32'(e_sl));
    chk("high_time", 32'(high_time), 32'(e_ht));
    chk("period", 32'(period), 32'(e_per));
    if (meas_valid === 1'b1) begin
      mv_seen++;
      if (int'(period) < min_per) min_per = int'(period);
    end
    rst_n  = 1'b1;
    pwm_in = v;
    line_q.push_back(v);
    if (line_q.size() > 8) void'(line_q.pop_front());
    model_step();
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) drive_cycle(v);
  endtask

  task automatic pulse_train(input int h, input int l, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  // Asserts reset between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("rst_stuck_high", 32'(stuck_high), 32'd0);
    chk("rst_stuck_low", 32'(stuck_low), 32'd0);
    chk("rst_high_time", 32'(high_time), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    model_reset();
    repeat (n) @(negedge clk);
  endtask

  initial begin
    apply_reset(2);

    // Steady 3/7: five periods give four measurements.
    mv_seen = 0;
    pulse_train(3, 7, 5);
    chk("steady_count", 32'(mv_seen), 32'd4);
    chk("steady_high", 32'(high_time), 32'd3);
    chk("steady_period", 32'(period), 32'd10);

    // Duty change 3/7 -> 8/2.
    pulse_train(3, 7, 2);
    pulse_train(8, 2, 3);
    chk("duty_high", 32'(high_time), 32'd8);
    chk("duty_period", 32'(period), 32'd10);

    // Stuck high after two good periods; results hold; a fall clears it.
    pulse_train(3, 7, 2);
    hold(1'b1, 60);
    chk("sh_flag", 32'(stuck_high), 32'd1);
    chk("sh_hold_high", 32'(high_time), 32'd3);
    chk("sh_hold_period", 32'(period), 32'd10);
    hold(1'b0, 10);
    chk("sh_cleared", 32'(stuck_high), 32'd0);

    // Random duty cycles including the 1/1 minimum.
    repeat (40) pulse_train($urandom_range(1, 12), $urandom_range(1, 12), 1);
    pulse_train(1, 1, 4);

    // Period exactly TIMEOUT_MAX is measured; one more cycle times out.
    pulse_train(20, 30, 1);
    pulse_train(3, 7, 1);
    chk("per_at_max", 32'(period), 32'd50);
    pulse_train(20, 31, 1);
    pulse_train(3, 7, 2);
    pulse_train(50, 5, 1);
    pulse_train(3, 7, 2);

    // Line static low from reset.
    apply_reset(2);
    hold(1'b0, 60);
    chk("sl_flag", 32'(stuck_low), 32'd1);
    chk("sl_no_meas", 32'(meas_valid), 32'd0);
    pulse_train(3, 7, 3);
    chk("sl_cleared", 32'(stuck_low), 32'd0);

    // Reset in the high phase of a 4/6 stream.
    pulse_train(4, 6, 3);
    hold(1'b1, 2);
    apply_reset(2);
    mv_seen = 0;
    pulse_train(4, 6, 3);
    chk("rst_mid_count", 32'(mv_seen), 32'd2);
    chk("rst_mid_high", 32'(high_time), 32'd4);
    chk("rst_mid_period", 32'(period), 32'd10);

    // 2-cycle glitch in the low phase of a 3/7 stream.
    pulse_train(3, 7, 2);
    min_per = 1000;
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 3);
    pulse_train(3, 7, 3);
`ifdef PWM_METER_DEGLITCH_EN
    chk("glitch_filtered", 32'(min_per), 32'd10);
`else
    chk("glitch_short_period", 32'(min_per < 10), 32'd1);
`endif

    // Random bit noise and long random holds (hits both timeouts).
    repeat (200) drive_cycle(1'($urandom_range(0, 1)));
    repeat (4) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(40, 70));
      pulse_train($urandom_range(1, 8), $urandom_range(1, 8), 2);
    end
    hold(1'b0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
